// File: rtl/serial_full_adder.sv
// Bit-serial adder: sum = a + b + carry_in, processed LSB first through one
// full-add cell and a carry flop, with a start/done handshake.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [1:0]       bit_sum;
    logic [WIDTH-1:0] acc_shift;

    // The single full-add cell; bit_sum = {carry, sum bit}.
    assign bit_sum   = {1'b0, sa_q[0]} + {1'b0, sb_q[0]} + {1'b0, c_q};
    assign acc_shift = WIDTH'({bit_sum[0], acc_q} >> 1);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = carry_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = acc_shift;
                c_d   = bit_sum[1];
                cnt_d = cnt_q + CW'(1);
                // Result registers capture the shifted value including this final bit.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_shift;
                    cout_d  = bit_sum[1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Scoreboard bench for serial_full_adder: directed cases plus random operands,
// expected results from plain integer addition, checked by a separate monitor.
module tb_serial_full_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int due);
        exp_t e;
        int   total;
        total  = int'(x) + int'(y) + int'(ci);
        e.sum  = W'(total % (1 << W));
        e.cout = (total >= (1 << W));
        e.due  = due;
        return e;
    endfunction

    // Monitor: busy must be high from the accepting edge through the done cycle;
    // each done pulse must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_busy;
            exp_t e;
            exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].due - W);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 exp done=0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e.sum || carry_out !== e.cout || cyc != e.due) begin
                        errors++;
                        $display("FAIL result cyc=%0d got sum=%h cout=%b exp sum=%h cout=%b due=%0d",
                                 cyc, sum, carry_out, e.sum, e.cout, e.due);
                    end else begin
                        $display("done cyc=%0d sum=%h cout=%b ok", cyc, sum, carry_out);
                    end
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_done cyc=%0d got done=%b exp done=1 sum=%h", cyc, done, e.sum);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout cyc=%0d got busy=%b exp busy=0", cyc, busy);
        end
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        wait_idle();
        a        = x;
        b        = y;
        carry_in = ci;
        start    = 1'b1;
        exp_q.push_back(model(x, y, ci, cyc + 1 + W));
        $display("start cyc=%0d a=%h b=%h cin=%b", cyc, x, y, ci);
        @(negedge clk);
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        carry_in = 1'($urandom);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b sum=%h cout=%b exp all 0",
                     name, busy, done, sum, carry_out);
        end
    endtask

    initial begin
        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        launch(8'h3C, 8'h05, 1'b0);
        launch(8'hFF, 8'h01, 1'b0);
        launch(8'hFF, 8'hFF, 1'b1);

        // Start raised while busy must be ignored.
        launch(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts without a done pulse.
        launch(8'h7F, 8'h7F, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_abort");
        exp_q.delete();
        $display("reset cyc=%0d", cyc);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        launch(8'h01, 8'h02, 1'b0);

        // Back-to-back with start held high: second done W+2 cycles later.
        launch(8'h80, 8'h80, 1'b0);
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        carry_in = 1'b0;
        begin
            int n = 0;
            while (done !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout cyc=%0d got done=%b exp done=1", cyc, done);
            end
        end
        a = 8'h01;
        b = 8'h01;
        exp_q.push_back(model(8'h01, 8'h01, 1'b0, cyc + 2 + W));
        $display("start(held) cyc=%0d a=01 b=01 cin=0", cyc);
        repeat (3) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(W'($urandom), W'($urandom), 1'($urandom));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending got=%0d outstanding exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
